// File: rtl/im_fetch_ctrl.sv
// Instruction-memory port-1 fetch controller: walks pc from start_addr to end_addr and
// streams words through a 2-entry valid/ready buffer. Define IM_FETCH_LOOP_EN for loop mode.
module im_fetch_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned RAM_DEPTH  = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH-1:0] end_addr,
    input  logic                  stop,
    output logic [ADDR_WIDTH-1:0] im_addr,
    output logic                  im_cs,
    output logic                  im_we,
    output logic                  im_oe,
    input  logic [DATA_WIDTH-1:0] im_data,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
`ifdef IM_FETCH_LOOP_EN
    input  logic                  loop_en,
`endif
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] end_q, end_d;
    logic [1:0]            count_q, count_d;
    logic [DATA_WIDTH-1:0] data_q [2];
    logic [DATA_WIDTH-1:0] data_d [2];
    logic [ADDR_WIDTH-1:0] pcb_q [2];
    logic [ADDR_WIDTH-1:0] pcb_d [2];

    logic                  fetch_en;
    logic                  pop;
    logic                  wr_idx;
    logic                  last;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic                  loop_run;
    logic [ADDR_WIDTH-1:0] reload_pc;

`ifdef IM_FETCH_LOOP_EN
    logic [ADDR_WIDTH-1:0] start_q, start_d;
    logic                  loop_q, loop_d;

    assign loop_run  = loop_q;
    assign reload_pc = start_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            start_q <= '0;
            loop_q  <= 1'b0;
        end else begin
            start_q <= start_d;
            loop_q  <= loop_d;
        end
    end

    always_comb begin
        start_d = start_q;
        loop_d  = loop_q;
        if (state_q == StIdle && start) begin
            start_d = start_addr;
            loop_d  = loop_en;
        end
    end
`else
    assign loop_run  = 1'b0;
    assign reload_pc = '0;
`endif

    // Fetch gating depends only on registered state, never on instr_ready.
    assign fetch_en    = (state_q == StFetch) && (count_q != 2'd2);
    assign instr_valid = (count_q != 2'd0);
    assign pop         = instr_valid && instr_ready;
    // Write slot: after an optional pop, the first free entry.
    assign wr_idx      = count_q[0] & ~pop;
    assign last        = (pc_q == end_q);
    assign pc_inc      = (pc_q == ADDR_WIDTH'(RAM_DEPTH - 1)) ? '0 : pc_q + 1'b1;

    assign im_addr    = pc_q;
    assign im_cs      = fetch_en;
    assign im_oe      = fetch_en;
    assign im_we      = 1'b0;
    assign instr_data = data_q[0];
    assign instr_pc   = pcb_q[0];
    assign busy       = (state_q == StFetch) || (state_q == StDrain);
    assign done       = (state_q == StDone);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        end_d   = end_q;
        count_d = count_q;
        data_d  = data_q;
        pcb_d   = pcb_q;

        if (pop) begin
            data_d[0] = data_q[1];
            pcb_d[0]  = pcb_q[1];
        end
        if (fetch_en) begin
            data_d[wr_idx] = im_data;
            pcb_d[wr_idx]  = pc_q;
        end
        unique case ({fetch_en, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                    pc_d    = start_addr;
                    end_d   = end_addr;
                    count_d = 2'd0;
                end
            end
            StFetch: begin
                if (stop) begin
                    state_d = StIdle;
                    count_d = 2'd0;
                end else if (fetch_en) begin
                    if (last && loop_run) begin
                        pc_d = reload_pc;
                    end else begin
                        pc_d = pc_inc;
                        if (last) state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (stop) begin
                    state_d = StIdle;
                    count_d = 2'd0;
                end else if (count_q == 2'd0) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            pc_q    <= '0;
            end_q   <= '0;
            count_q <= 2'd0;
            data_q  <= '{default: '0};
            pcb_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            end_q   <= end_d;
            count_q <= count_d;
            data_q  <= data_d;
            pcb_q   <= pcb_d;
        end
    end

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Scoreboard bench for im_fetch_ctrl: stimulus pushes expected (pc, data) pairs,
// a negedge monitor pops and compares on every handshake.
module tb_im_fetch_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] end_addr;
    logic          stop;
    logic [AW-1:0] im_addr;
    logic          im_cs;
    logic          im_we;
    logic          im_oe;
    logic [DW-1:0] im_data;
    logic [DW-1:0] instr_data;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic          busy;
    logic          done;
`ifdef IM_FETCH_LOOP_EN
    logic          loop_en;
`endif

    always #5 clk = ~clk;

    im_fetch_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .RAM_DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .start_addr  (start_addr),
        .end_addr    (end_addr),
        .stop        (stop),
        .im_addr     (im_addr),
        .im_cs       (im_cs),
        .im_we       (im_we),
        .im_oe       (im_oe),
        .im_data     (im_data),
        .instr_data  (instr_data),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
`ifdef IM_FETCH_LOOP_EN
        .loop_en     (loop_en),
`endif
        .busy        (busy),
        .done        (done)
    );

    logic [DW-1:0] mem [DEPTH];
    assign im_data = (im_cs && im_oe) ? mem[im_addr] : '0;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   total     = 0;
    int   bad       = 0;
    int   cyc       = 0;
    int   delivered = 0;
    int   done_cnt  = 0;
    int   done_cyc  = -1;
    int   first_hs  = -1;
    int   last_hs   = -1;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endfunction

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(negedge clk);
            cyc++;
            total++;
            if (im_we !== 1'b0) begin
                bad++;
                $display("FAIL im_we: got %0b want 0", im_we);
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (reset_n === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
                got = '{pc: instr_pc, data: instr_data};
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_instr: got pc=%0d data=%0h want none",
                             instr_pc, instr_data);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        bad++;
                        $display("FAIL instr: got pc=%0d data=%0h want pc=%0d data=%0h",
                                 got.pc, got.data, e.pc, e.data);
                    end
                end
                delivered++;
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [AW-1:0] s, input logic [AW-1:0] e, input bit push_exp);
        int len;
        int a;
        len = ((int'(e) - int'(s) + DEPTH) % DEPTH) + 1;
        if (push_exp) begin
            for (int k = 0; k < len; k++) begin
                a = (int'(s) + k) % DEPTH;
                exp_q.push_back('{pc: AW'(a), data: mem[a]});
            end
        end
        delivered  = 0;
        first_hs   = -1;
        start      = 1'b1;
        start_addr = s;
        end_addr   = e;
        tick(1);
        start      = 1'b0;
    endtask

    task automatic wait_done(input int maxc, input bit toggle, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (toggle) instr_ready = ~instr_ready;
            tick(1);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        int dc;

        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h5A00_0000 | (i * 32'h101);
        mem[4] = 32'hA0;
        mem[5] = 32'hA1;
        mem[6] = 32'hA2;
        mem[7] = 32'hA3;

        reset_n     = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        start_addr  = '0;
        end_addr    = '0;
        instr_ready = 1'b0;
`ifdef IM_FETCH_LOOP_EN
        loop_en     = 1'b0;
`endif

        // Reset state
        tick(2);
        check("rst_im_addr", 64'(im_addr), 64'd0);
        check("rst_im_cs", 64'(im_cs), 64'd0);
        check("rst_im_oe", 64'(im_oe), 64'd0);
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_data", 64'(instr_data), 64'd0);
        check("rst_pc", 64'(instr_pc), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        reset_n = 1'b1;
        tick(1);

        // Streaming run 4..7 with ready held high
        instr_ready = 1'b1;
        dc = done_cnt;
        run(6'd4, 6'd7, 1'b1);
        wait_done(40, 1'b0, ok);
        check("t2_done_seen", 64'(ok), 64'd1);
        tick(2);
        check("t2_words", 64'(delivered), 64'd4);
        check("t2_consecutive", 64'(last_hs - first_hs), 64'd3);
        check("t2_done_lat", 64'(done_cyc - last_hs), 64'd2);
        check("t2_done_once", 64'(done_cnt - dc), 64'd1);
        check("t2_busy_after", 64'(busy), 64'd0);
        check("t2_q_empty", 64'(exp_q.size()), 64'd0);

        // Backpressure 0..9
        instr_ready = 1'b0;
        run(6'd0, 6'd9, 1'b1);
        tick(4);
        check("t3_cs_drop", 64'(im_cs), 64'd0);
        check("t3_pc", 64'(im_addr), 64'd2);
        check("t3_valid", 64'(instr_valid), 64'd1);
        tick(2);
        check("t3_hold_pc", 64'(instr_pc), 64'd0);
        check("t3_hold_data", 64'(instr_data), 64'(mem[0]));
        wait_done(100, 1'b1, ok);
        check("t3_done_seen", 64'(ok), 64'd1);
        instr_ready = 1'b1;
        tick(2);
        check("t3_words", 64'(delivered), 64'd10);
        check("t3_q_empty", 64'(exp_q.size()), 64'd0);

        // Wrap-around and single-word runs
        run(6'd62, 6'd1, 1'b1);
        wait_done(40, 1'b0, ok);
        check("t4_done_seen", 64'(ok), 64'd1);
        tick(2);
        check("t4_words", 64'(delivered), 64'd4);
        check("t4_q_empty", 64'(exp_q.size()), 64'd0);
        run(6'd5, 6'd5, 1'b1);
        wait_done(40, 1'b0, ok);
        check("t4b_done_seen", 64'(ok), 64'd1);
        tick(2);
        check("t4b_words", 64'(delivered), 64'd1);
        check("t4b_q_empty", 64'(exp_q.size()), 64'd0);

        // Stop after three words, then reset mid-run
        dc = done_cnt;
        run(6'd0, 6'd9, 1'b1);
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (delivered >= 3) break;
        end
        instr_ready = 1'b0;
        check("t5_words_before_stop", 64'(delivered), 64'd3);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        exp_q.delete();
        check("t5_stop_busy", 64'(busy), 64'd0);
        check("t5_stop_valid", 64'(instr_valid), 64'd0);
        check("t5_stop_cs", 64'(im_cs), 64'd0);
        tick(5);
        check("t5_stop_no_done", 64'(done_cnt - dc), 64'd0);

        run(6'd0, 6'd9, 1'b0);
        tick(3);
        check("t5_run2_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        check("t5_rst_valid", 64'(instr_valid), 64'd0);
        check("t5_rst_busy", 64'(busy), 64'd0);
        check("t5_rst_addr", 64'(im_addr), 64'd0);
        tick(5);
        check("t5_rst_no_done", 64'(done_cnt - dc), 64'd0);

        instr_ready = 1'b1;
        run(6'd20, 6'd23, 1'b1);
        wait_done(40, 1'b0, ok);
        check("t5_clean_done_seen", 64'(ok), 64'd1);
        tick(2);
        check("t5_clean_words", 64'(delivered), 64'd4);
        check("t5_clean_done_once", 64'(done_cnt - dc), 64'd1);
        check("t5_clean_q_empty", 64'(exp_q.size()), 64'd0);

`ifdef IM_FETCH_LOOP_EN
        // Loop mode over 2..3 until stopped
        dc      = done_cnt;
        loop_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back('{pc: AW'(2), data: mem[2]});
            exp_q.push_back('{pc: AW'(3), data: mem[3]});
        end
        run(6'd2, 6'd3, 1'b0);
        loop_en = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (delivered >= 6) break;
        end
        instr_ready = 1'b0;
        check("t6_words", 64'(delivered), 64'd6);
        check("t6_still_busy", 64'(busy), 64'd1);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        exp_q.delete();
        tick(4);
        check("t6_busy_after_stop", 64'(busy), 64'd0);
        check("t6_no_done", 64'(done_cnt - dc), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
